ripple_count_extender: RTL and testbench
========================================

# ripple_count_extender

- Synchronous consumer placed directly downstream of the 4-bit asynchronous up/down ripple counter.
- Samples the ripple counter's asynchronous `q` bus into the `clk` domain and filters ripple glitches by requiring two equal consecutive samples.
- Tracks counter wrap-around in the direction given by `m` and extends the 4-bit count into a wider position value.
- Reports delivery of each new value, and flags any observed step that is not a single count in the commanded direction.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on `cnt_in`; must be ≥2.
- `HI_W`, default 4: width of the wrap-extension (high) field; `pos` is `HI_W+4` bits.
- `clk` input, 1: single clock; all state updates on its rising edge.
- `res_n` input, 1: reset, synchronous, active-low.
- `cnt_in` input, 4: ripple counter `q`; asynchronous to `clk`, may glitch during ripple.
- `m` input, 1: counter direction; 1 = up, 0 = down; synchronous to `clk`.
- `clr` input, 1: synchronous clear of `hi` and `err`.
- `pos` output, HI_W+4: `{hi, cnt_q}`, the extended position.
- `cnt_vld` output, 1: one-cycle pulse when `pos` takes a new accepted value.
- `wrap_up` output, 1: one-cycle pulse on an accepted 15→0 step with `m`=1.
- `wrap_dn` output, 1: one-cycle pulse on an accepted 0→15 step with `m`=0.
- `err` output, 1: sticky skip/direction error; present only with `SKIP_DET_EN`, otherwise tied 0.

## Operation
- **Sync chain:** `SYNC_STAGES` flops on `cnt_in`, producing `s`. Register `p` holds `s` delayed by one cycle.
- **Accept condition:** `s == p`, and either `s != cnt_q` or `primed == 0`.
- **On accept:** `cnt_q <= s` and `cnt_vld` pulses.
- **Priming:** the first accept after reset (`primed == 0`) loads `cnt_q`, sets `primed`, and pulses `cnt_vld`. It performs no wrap or error evaluation.
- **Primed accept, up:** `m`=1, old `cnt_q`=15, new 0 → `hi <= hi+1` (modulo 2^HI_W) and `wrap_up` pulses.
- **Primed accept, down:** `m`=0, old 0, new 15 → `hi <= hi-1` (modulo) and `wrap_dn` pulses.
- **Other legal steps:** `hi` is unchanged.
- **Wrap wrap-around:** `hi` wraps silently: 2^HI_W-1 + 1 → 0, and 0 - 1 → 2^HI_W-1.
- **Legal step:** delta = (new - old) mod 16 must be 1 for `m`=1 and 15 for `m`=0.
- **Illegal step:** any other delta on a primed accept updates `cnt_q` and pulses `cnt_vld`. It never changes `hi` and never pulses `wrap_*`, even if the values are 15/0.
- **`m` stability:** `m` must be held stable from `SYNC_STAGES+2` cycles before the `cnt_in` change until the accept. `m` is sampled in the accept cycle.
- **`clr`:** clears `hi` and `err` next edge; `cnt_q` and `primed` are unaffected.
- **`clr` vs wrap:** `clr` wins over a same-cycle wrap: `hi`=0, but the `wrap_*` pulse still fires.
- **Reset (`res_n`=0 at an edge):** sync flops, `p`, `cnt_q`, `hi`, `primed`, `err`, and all pulses are cleared to 0. Reset applied mid-operation discards any in-flight sample. `pos`=0, `cnt_vld`=`wrap_up`=`wrap_dn`=0.

## Timing
- **Latency:** `cnt_in` stable before edge k → `s` valid after edge k+SYNC_STAGES-1, `p` matches after edge k+SYNC_STAGES, and `pos`/`cnt_vld`/`wrap_*` update at edge k+SYNC_STAGES+1. That is 4 edges at default.
- **Minimum count period:** `cnt_in` must hold ≥ SYNC_STAGES+2 `clk` cycles per count. Faster counting is caught as a skip (`err`) under `SKIP_DET_EN`.
- **Pulse alignment:** all pulses are exactly one cycle wide, and are coincident with the `pos` update.
- **No back-pressure:** there is no handshake; the consumer must capture `pos` on `cnt_vld`.
- **Glitches:** ripple transients shorter than one `clk` period never produce an accept.

## Configuration
- **`SKIP_DET_EN` defined:** the delta checker is present. `err` sets at the accept edge of an illegal step; `clr` clears it. If set and clear coincide, set wins.
- **`SKIP_DET_EN` undefined:** the checker logic is removed and `err` is constant 0. Accept, wrap, and `hi` behaviour are identical in both builds.

## Test plan
- Reset with `cnt_in`=5 held, release → `cnt_vld` pulses once at edge 4 after release with `pos`=0x05; `err`=0; no `wrap_*`.
- `m`=1, step `cnt_in` 13→14→15→0→1, each held 6 cycles → 4 `cnt_vld` pulses, one `wrap_up` on the 15→0 step, final `pos`=0x11.
- `m`=0 from `pos`=0x10: step 0→15 → `wrap_dn` pulses, `pos`=0x0F; with `hi`=0, repeat 0→15 → `pos`=0xFF (modulo wrap).
- 1-cycle glitch `cnt_in` 3→7→3 during ripple → no `cnt_vld`, `pos` unchanged.
- With `SKIP_DET_EN`, `m`=1, jump 2→4 → `pos` low nibble 4, `err`=1 sticky. Assert `clr` → `err`=0, `hi`=0. Without the macro, `err` stays 0.
- Assert `res_n`=0 one cycle after a `cnt_in` change → all outputs 0 next edge; no late `cnt_vld` after release for the discarded sample.

Source files
------------

// File: rtl/ripple_count_extender.sv
// rtl/ripple_count_extender.sv - samples a ripple counter into clk and extends it with a wrap count
// Optional skip/direction checker: SKIP_DET_EN
module ripple_count_extender #(
    parameter int SYNC_STAGES = 2,
    parameter int HI_W        = 4
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic [3:0]        cnt_in,
    input  logic              m,
    input  logic              clr,
    output logic [HI_W+3:0]   pos,
    output logic              cnt_vld,
    output logic              wrap_up,
    output logic              wrap_dn,
    output logic              err
);

    localparam logic [HI_W-1:0] HI_ONE = 1;

    logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
    // fill_q marks which pipeline stages hold real samples taken since reset
    logic [SYNC_STAGES:0]        fill_q, fill_d;
    logic [3:0]                  p_q, p_d;
    logic [3:0]                  cnt_q, cnt_d;
    logic [HI_W-1:0]             hi_q, hi_d;
    logic                        primed_q, primed_d;
    logic                        cnt_vld_q, cnt_vld_d;
    logic                        wrap_up_q, wrap_up_d;
    logic                        wrap_dn_q, wrap_dn_d;
    logic [3:0]                  s;
    logic                        accept;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], cnt_in};
        fill_d    = {fill_q[SYNC_STAGES-1:0], 1'b1};
        p_d       = s;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        primed_d  = primed_q;
        cnt_vld_d = 1'b0;
        wrap_up_d = 1'b0;
        wrap_dn_d = 1'b0;
        accept    = fill_q[SYNC_STAGES] && (s == p_q) && ((s != cnt_q) || !primed_q);
        if (accept) begin
            cnt_d     = s;
            cnt_vld_d = 1'b1;
            primed_d  = 1'b1;
            if (primed_q && m && (cnt_q == 4'd15) && (s == 4'd0)) begin
                hi_d      = hi_q + HI_ONE;
                wrap_up_d = 1'b1;
            end
            if (primed_q && !m && (cnt_q == 4'd0) && (s == 4'd15)) begin
                hi_d      = hi_q - HI_ONE;
                wrap_dn_d = 1'b1;
            end
        end
        if (clr) begin
            hi_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            sync_q    <= '0;
            fill_q    <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            primed_q  <= 1'b0;
            cnt_vld_q <= 1'b0;
            wrap_up_q <= 1'b0;
            wrap_dn_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            fill_q    <= fill_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            primed_q  <= primed_d;
            cnt_vld_q <= cnt_vld_d;
            wrap_up_q <= wrap_up_d;
            wrap_dn_q <= wrap_dn_d;
        end
    end

`ifdef SKIP_DET_EN
    logic [3:0] delta;
    logic       step_ok;
    logic       err_q, err_d;

    always_comb begin
        delta   = s - cnt_q;
        step_ok = m ? (delta == 4'd1) : (delta == 4'd15);
        err_d   = err_q;
        if (clr) begin
            err_d = 1'b0;
        end
        // a coincident illegal step outranks clr
        if (accept && primed_q && !step_ok) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign pos     = {hi_q, cnt_q};
    assign cnt_vld = cnt_vld_q;
    assign wrap_up = wrap_up_q;
    assign wrap_dn = wrap_dn_q;

endmodule

// File: tb/tb_ripple_count_extender.sv
// tb/tb_ripple_count_extender.sv - directed self-checking bench for ripple_count_extender
module tb_ripple_count_extender;

    logic       clk = 1'b0;
    logic       res_n;
    logic [3:0] cnt_in;
    logic       m;
    logic       clr;
    logic [7:0] pos;
    logic       cnt_vld;
    logic       wrap_up;
    logic       wrap_dn;
    logic       err;

    int checks = 0;
    int errors = 0;
    int vld_cnt;
    int wu_cnt;
    int wd_cnt;

`ifdef SKIP_DET_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    ripple_count_extender #(.SYNC_STAGES(2), .HI_W(4)) dut (
        .clk     (clk),
        .res_n   (res_n),
        .cnt_in  (cnt_in),
        .m       (m),
        .clr     (clr),
        .pos     (pos),
        .cnt_vld (cnt_vld),
        .wrap_up (wrap_up),
        .wrap_dn (wrap_dn),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        vld_cnt = 0;
        wu_cnt  = 0;
        wd_cnt  = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        vld_cnt += int'(cnt_vld);
        wu_cnt  += int'(wrap_up);
        wd_cnt  += int'(wrap_dn);
    endtask

    // one count held 6 cycles; accept lands on the 4th edge after the change
    task automatic step(input string tag, input logic [3:0] v, input logic [7:0] exp_pos,
                        input logic exp_wu, input logic exp_wd, input logic with_clr);
        cnt_in = v;
        clear_counts();
        repeat (3) tick();
        check({tag, "_early_vld"}, vld_cnt, 0);
        clr = with_clr;
        tick();
        clr = 1'b0;
        check({tag, "_vld"}, cnt_vld, 1);
        check({tag, "_pos"}, pos, exp_pos);
        check({tag, "_wraps"}, {wrap_up, wrap_dn}, {exp_wu, exp_wd});
        repeat (2) tick();
        check({tag, "_vld_total"}, vld_cnt, 1);
    endtask

    initial begin
        res_n  = 1'b0;
        cnt_in = 4'd5;
        m      = 1'b1;
        clr    = 1'b0;
        clear_counts();
        repeat (3) tick();
        check("rst_pos", pos, 0);
        check("rst_vld", cnt_vld, 0);
        check("rst_err", err, 0);

        res_n = 1'b1;
        clear_counts();
        repeat (3) tick();
        check("prime_early_vld", vld_cnt, 0);
        tick();
        check("prime_vld", cnt_vld, 1);
        check("prime_pos", pos, 8'h05);
        check("prime_err", err, 0);
        check("prime_wraps", {wrap_up, wrap_dn}, 0);
        repeat (3) tick();
        check("prime_vld_total", vld_cnt, 1);

        res_n  = 1'b0;
        cnt_in = 4'd13;
        repeat (2) tick();
        res_n = 1'b1;
        repeat (6) tick();
        check("start13_pos", pos, 8'h0D);

        step("up14", 4'd14, 8'h0E, 1'b0, 1'b0, 1'b0);
        step("up15", 4'd15, 8'h0F, 1'b0, 1'b0, 1'b0);
        step("up0",  4'd0,  8'h10, 1'b1, 1'b0, 1'b0);
        step("up1",  4'd1,  8'h11, 1'b0, 1'b0, 1'b0);
        check("up_err", err, 0);

        m = 1'b0;
        step("dn0",  4'd0,  8'h10, 1'b0, 1'b0, 1'b0);
        step("dn15", 4'd15, 8'h0F, 1'b0, 1'b1, 1'b0);

        m = 1'b1;
        step("clr_wrap", 4'd0, 8'h00, 1'b1, 1'b0, 1'b1);

        m = 1'b0;
        step("dn_mod", 4'd15, 8'hFF, 1'b0, 1'b1, 1'b0);
        check("dn_err", err, 0);

        clear_counts();
        cnt_in = 4'd7;
        tick();
        cnt_in = 4'd15;
        repeat (8) tick();
        check("glitch_vld", vld_cnt, 0);
        check("glitch_pos", pos, 8'hFF);

        m = 1'b1;
        step("rewrap", 4'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        step("s1", 4'd1, 8'h01, 1'b0, 1'b0, 1'b0);
        step("s2", 4'd2, 8'h02, 1'b0, 1'b0, 1'b0);
        step("skip", 4'd4, 8'h04, 1'b0, 1'b0, 1'b0);
        check("skip_err", err, EXP_ERR);
        repeat (5) tick();
        check("skip_err_sticky", err, EXP_ERR);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_err", err, 0);
        check("clr_pos", pos, 8'h04);

        cnt_in = 4'd9;
        tick();
        res_n = 1'b0;
        tick();
        check("mid_rst_pos", pos, 0);
        check("mid_rst_vld", cnt_vld, 0);
        check("mid_rst_wraps", {wrap_up, wrap_dn}, 0);
        check("mid_rst_err", err, 0);
        tick();
        res_n = 1'b1;
        clear_counts();
        repeat (3) tick();
        check("mid_rst_late_vld", vld_cnt, 0);
        tick();
        check("reprime_vld", cnt_vld, 1);
        check("reprime_pos", pos, 8'h09);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
